// File: rtl/tx_prbs_gen_pkg.sv
// Shared types and constants for the TX PRBS generator and its LFSR core.
package tx_package;

  localparam int PRBS_MAX_WIDTH = 31;

  typedef enum logic [1:0] {
    PRBS7    = 2'd0,
    PRBS15   = 2'd1,
    PRBS31   = 2'd2,
    PRBS_CLK = 2'd3
  } prbs_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } prbs_state_t;

  localparam logic [PRBS_MAX_WIDTH-1:0] MASK_PRBS7  = 31'h0000_007F;
  localparam logic [PRBS_MAX_WIDTH-1:0] MASK_PRBS15 = 31'h0000_7FFF;
  localparam logic [PRBS_MAX_WIDTH-1:0] MASK_PRBS31 = 31'h7FFF_FFFF;

  localparam int TAP7_HI  = 6;
  localparam int TAP7_LO  = 5;
  localparam int TAP15_HI = 14;
  localparam int TAP15_LO = 13;
  localparam int TAP31_HI = 30;
  localparam int TAP31_LO = 27;

  // CLK mode keeps the PRBS7 width so the frozen register stays non-zero.
  function automatic logic [PRBS_MAX_WIDTH-1:0] prbs_mask(input prbs_mode_t mode);
    case (mode)
      PRBS15:  return MASK_PRBS15;
      PRBS31:  return MASK_PRBS31;
      default: return MASK_PRBS7;
    endcase
  endfunction

endpackage

// File: rtl/tx_prbs_gen_lfsr.sv
// Fibonacci LFSR core: mode-selected feedback, load/advance and zero-state recovery.
module prbs_lfsr
  import tx_package::*;
#(
  parameter logic [PRBS_MAX_WIDTH-1:0] SEED = 31'h7FFF_FFFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  prbs_mode_t                i_mode,
  input  logic                      i_load,
  input  logic [PRBS_MAX_WIDTH-1:0] i_load_val,
  input  logic                      i_adv,
  output logic                      o_fb,
  output logic                      o_zero,
  output logic                      o_load_zero
);

  localparam int W = PRBS_MAX_WIDTH;

  logic [W-1:0] r_state;
  logic [W-1:0] w_mask;
  logic [W-1:0] w_cur;
  logic [W-1:0] w_load;
  logic [W-1:0] w_next;
  logic [W-1:0] w_recover;

  assign w_mask      = prbs_mask(i_mode);
  assign w_cur       = r_state & w_mask;
  assign w_load      = i_load_val & w_mask;
  assign w_recover   = SEED & w_mask;
  assign o_zero      = (w_cur == '0);
  assign o_load_zero = (w_load == '0);

  always_comb begin
    case (i_mode)
      PRBS15:  o_fb = r_state[TAP15_HI] ^ r_state[TAP15_LO];
      PRBS31:  o_fb = r_state[TAP31_HI] ^ r_state[TAP31_LO];
      default: o_fb = r_state[TAP7_HI] ^ r_state[TAP7_LO];
    endcase
  end

  assign w_next = ((r_state << 1) | {{(W-1){1'b0}}, o_fb}) & w_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED & MASK_PRBS7;
    end else if (i_load) begin
      r_state <= o_load_zero ? w_recover : w_load;
    end else if (i_adv) begin
      r_state <= o_zero ? w_recover : w_next;
    end
  end

endmodule

// File: rtl/tx_prbs_gen.sv
// Serial PRBS7/15/31 and 1010 clock-pattern source feeding the TX FFE.
// Optional single-bit error injection is enabled by defining TX_PRBS_ERR_INJ_EN.
module tx_prbs_gen
  import tx_package::*;
#(
  parameter logic [PRBS_MAX_WIDTH-1:0] SEED      = 31'h7FFF_FFFF,
  parameter int                        CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  prbs_mode_t                mode,
  input  logic                      seed_load,
  input  logic [PRBS_MAX_WIDTH-1:0] seed,
  input  logic                      err_inj,
  output logic                      out,
  output logic                      out_valid,
  output logic                      lockup,
  output logic [CNT_WIDTH-1:0]      bit_cnt,
  output logic [CNT_WIDTH-1:0]      err_cnt
);

  prbs_state_t              r_fsm;
  prbs_mode_t               r_mode;
  logic                     r_load_pend;
  logic                     r_clk_bit;
  logic                     r_out;
  logic                     r_out_valid;
  logic                     r_lockup;
  logic [CNT_WIDTH-1:0]     r_bit_cnt;

  logic                      w_run_en;
  logic                      w_load;
  logic                      w_adv;
  logic                      w_emit;
  logic                      w_fb;
  logic                      w_zero;
  logic                      w_load_zero;
  logic                      w_raw_bit;
  logic                      w_inj;
  logic                      w_bit;
  prbs_mode_t                w_lfsr_mode;
  logic [PRBS_MAX_WIDTH-1:0] w_load_val;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign w_run_en    = (r_fsm == RUN) && en;
  assign w_load      = (r_fsm == LOAD);
  assign w_lfsr_mode = w_load ? mode : r_mode;
  assign w_load_val  = (r_load_pend || seed_load) ? seed : SEED;
  assign w_adv       = w_run_en && (r_mode != PRBS_CLK);
  assign w_emit      = w_run_en && ((r_mode == PRBS_CLK) || !w_zero);
  assign w_raw_bit   = (r_mode == PRBS_CLK) ? ~r_clk_bit : w_fb;
  assign w_bit       = w_raw_bit ^ w_inj;

  prbs_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_mode     (w_lfsr_mode),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_adv      (w_adv),
    .o_fb       (w_fb),
    .o_zero     (w_zero),
    .o_load_zero(w_load_zero)
  );

  // The cycle that requests a reload still emits one bit of the old pattern,
  // so a mode switch costs exactly the single LOAD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= IDLE;
      r_mode      <= PRBS7;
      r_load_pend <= 1'b0;
      r_clk_bit   <= 1'b0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_lockup    <= 1'b0;
      r_bit_cnt   <= '0;
    end else begin
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (seed_load) r_load_pend <= 1'b1;
          if (en)        r_fsm       <= LOAD;
        end
        LOAD: begin
          r_mode      <= mode;
          r_load_pend <= 1'b0;
          r_clk_bit   <= 1'b0;
          if (w_load_zero) r_lockup <= 1'b1;
          r_fsm       <= RUN;
        end
        RUN: begin
          if (seed_load) r_load_pend <= 1'b1;
          if (!en) begin
            r_fsm <= IDLE;
          end else begin
            if (seed_load || (mode != r_mode)) r_fsm <= LOAD;
            if (w_emit) begin
              r_out       <= w_bit;
              r_out_valid <= 1'b1;
              r_bit_cnt   <= sat_inc(r_bit_cnt);
              if (r_mode == PRBS_CLK) r_clk_bit <= ~r_clk_bit;
            end else begin
              r_lockup <= 1'b1;
            end
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

`ifdef TX_PRBS_ERR_INJ_EN
  logic                 r_err_arm;
  logic [CNT_WIDTH-1:0] r_err_cnt;

  assign w_inj   = w_emit && (r_err_arm || err_inj);
  assign err_cnt = r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_arm <= 1'b0;
      r_err_cnt <= '0;
    end else if (!w_run_en) begin
      r_err_arm <= 1'b0;
    end else if (w_emit) begin
      r_err_arm <= 1'b0;
      if (w_inj) r_err_cnt <= sat_inc(r_err_cnt);
    end else begin
      r_err_arm <= r_err_arm | err_inj;
    end
  end
`else
  logic w_unused_err_inj;

  assign w_unused_err_inj = err_inj;
  assign w_inj            = 1'b0;
  assign err_cnt          = '0;
`endif

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign lockup    = r_lockup;
  assign bit_cnt   = r_bit_cnt;

endmodule
